// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit UART transmitter, 1 start bit, LSB-first data,
// optional even/odd parity bit, 1 stop bit.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//   PARITY       : 0 none, 1 even, 2 odd
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   tx_dv     in   byte-valid strobe, accepted only while idle
//   tx_data   in   byte to send, latched on accept
//   tx_serial out  serial line, idles high (registered)
//   tx_ready  out  high while idle, a new byte can be accepted (registered)
//   tx_active out  high while a frame is on the line (registered)
//   tx_done   out  one-cycle pulse on the first idle cycle after a frame (registered)
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_dv,
  input  logic [7:0] tx_data,
  output logic       tx_serial,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [CNT_W-1:0] w_clk_cnt_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             r_parity;
  logic             w_parity_next;
  logic             r_tx_serial;
  logic             r_tx_ready;
  logic             r_tx_active;
  logic             r_tx_done;
  logic             w_tx_serial_next;
  logic             w_tx_ready_next;
  logic             w_tx_active_next;
  logic             w_tx_done_next;
  logic             w_bit_end;

  assign w_bit_end = (r_clk_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (tx_dv) w_next_state = S_START;
      S_START:  if (w_bit_end) w_next_state = S_DATA;
      S_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
          w_next_state = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (w_bit_end) w_next_state = S_STOP;
      S_STOP:   if (w_bit_end) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath next values: bit-time counter, data bit index, shift register, parity
  always_comb begin
    w_clk_cnt_next = r_clk_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    if (r_state == S_IDLE) begin
      w_clk_cnt_next = '0;
      w_bit_idx_next = '0;
      if (tx_dv) begin
        w_shift_next  = tx_data;
        // Odd parity is the inverse of the even-parity XOR
        w_parity_next = (^tx_data) ^ (PARITY == 2);
      end
    end else if (w_bit_end) begin
      w_clk_cnt_next = '0;
      if (r_state == S_DATA) begin
        w_bit_idx_next = r_bit_idx + 3'd1;
        w_shift_next   = {1'b0, r_shift[7:1]};
      end
    end else begin
      w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
    end
  end

  // Output logic: values computed from the upcoming state so the registered
  // outputs line up with the state they describe
  always_comb begin
    w_tx_serial_next = 1'b1;
    w_tx_ready_next  = (w_next_state == S_IDLE);
    w_tx_active_next = (w_next_state != S_IDLE);
    w_tx_done_next   = (r_state == S_STOP) && (w_next_state == S_IDLE);
    case (w_next_state)
      S_START:  w_tx_serial_next = 1'b0;
      S_DATA:   w_tx_serial_next = w_shift_next[0];
      S_PARITY: w_tx_serial_next = r_parity;
      default:  w_tx_serial_next = 1'b1;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tx_serial <= 1'b1;
      r_tx_ready  <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_clk_cnt   <= w_clk_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_parity    <= w_parity_next;
      r_tx_serial <= w_tx_serial_next;
      r_tx_ready  <= w_tx_ready_next;
      r_tx_active <= w_tx_active_next;
      r_tx_done   <= w_tx_done_next;
    end
  end

  assign tx_serial = r_tx_serial;
  assign tx_ready  = r_tx_ready;
  assign tx_active = r_tx_active;
  assign tx_done   = r_tx_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: three transmitters (no/even/odd parity, 8 clocks per bit)
// checked cycle by cycle against a frame-level reference model.
module tb_uart_transmitter;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dv;
  logic [7:0] data;
  logic [2:0] ser, rdy, act, dn;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY(0)) u_p0 (
    .clk(clk), .rst(rst), .tx_dv(dv[0]), .tx_data(data),
    .tx_serial(ser[0]), .tx_ready(rdy[0]), .tx_active(act[0]), .tx_done(dn[0]));
  uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_p1 (
    .clk(clk), .rst(rst), .tx_dv(dv[1]), .tx_data(data),
    .tx_serial(ser[1]), .tx_ready(rdy[1]), .tx_active(act[1]), .tx_done(dn[1]));
  uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_p2 (
    .clk(clk), .rst(rst), .tx_dv(dv[2]), .tx_data(data),
    .tx_serial(ser[2]), .tx_ready(rdy[2]), .tx_active(act[2]), .tx_done(dn[2]));

  typedef struct {
    int         mode;
    logic [7:0] byte_v;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, a, e, $time);
    end
  endtask

  task automatic chki(input string name, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, a, e, $time);
    end
  endtask

  // Reference model: number of bits in a frame and the value of line bit idx
  function automatic int frame_bits(input int mode);
    return (mode != 0) ? 11 : 10;
  endfunction

  function automatic logic model_bit(input logic [7:0] b, input int mode, input int idx);
    int ones;
    ones = $countones(b);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (mode != 0 && idx == 9) return (mode == 1) ? 1'(ones % 2) : 1'((ones + 1) % 2);
    return 1'b1;
  endfunction

  // Send one byte on instance m and follow the frame cycle by cycle.
  // busy_at > 0 pulses tx_dv with busy_b on that frame cycle (must be ignored).
  // line returns the bits seen mid-bit on the line (a simple receiver).
  task automatic send(input int m, input logic [7:0] b, input int busy_at,
                      input logic [7:0] busy_b, output int done_cycle,
                      output logic [15:0] line);
    int n;
    n = frame_bits(m) * CPB;
    done_cycle = -1;
    line = '0;
    data = b;
    dv[m] = 1'b1;
    tick();
    dv[m] = 1'b0;
    data = 8'($urandom);
    for (int k = 1; k <= n + 5; k++) begin
      if (dn[m] && done_cycle < 0) done_cycle = k;
      if (k <= n) begin
        chk1("serial", ser[m], model_bit(b, m, (k - 1) / CPB));
        chk1("active_in_frame", act[m], 1'b1);
        chk1("ready_in_frame", rdy[m], 1'b0);
        chk1("done_in_frame", dn[m], 1'b0);
        if ((k - 1) % CPB == CPB / 2) line[(k - 1) / CPB] = ser[m];
      end else if (k == n + 1) begin
        chk1("done_pulse", dn[m], 1'b1);
        chk1("ready_on_done", rdy[m], 1'b1);
        chk1("active_on_done", act[m], 1'b0);
        chk1("serial_on_done", ser[m], 1'b1);
      end else begin
        chk1("done_after", dn[m], 1'b0);
        chk1("active_after", act[m], 1'b0);
        chk1("serial_after", ser[m], 1'b1);
      end
      if (k == busy_at) begin
        dv[m] = 1'b1;
        data = busy_b;
      end else begin
        dv[m] = 1'b0;
      end
      tick();
    end
    dv[m] = 1'b0;
  endtask

  initial begin
    int          dc;
    logic [15:0] ln;
    logic [7:0]  rb;
    int          md;
    int          d1, d2, pulses;

    rst  = 1'b1;
    dv   = '0;
    data = '0;
    tick();
    tick();
    // Reset state
    chki("reset_serial", int'(ser), 7);
    chki("reset_ready", int'(rdy), 7);
    chki("reset_active", int'(act), 0);
    chki("reset_done", int'(dn), 0);

    // Reset and tx_dv together: reset wins
    dv = 3'b111;
    data = 8'h55;
    tick();
    rst = 1'b0;
    dv = '0;
    chki("rst_dv_active", int'(act), 0);
    chki("rst_dv_serial", int'(ser), 7);
    tick();
    chki("rst_dv_active2", int'(act), 0);
    chki("rst_dv_ready2", int'(rdy), 7);

    // Table of parity / frame-length vectors
    vecs = '{
      '{1, 8'h07, 1'b1, 88},
      '{2, 8'h07, 1'b0, 88},
      '{1, 8'h00, 1'b0, 88},
      '{2, 8'h00, 1'b1, 88},
      '{1, 8'hFF, 1'b0, 88},
      '{2, 8'h81, 1'b1, 88},
      '{0, 8'hA5, 1'b1, 80}
    };
    foreach (vecs[i]) begin
      send(vecs[i].mode, vecs[i].byte_v, 0, 8'h00, dc, ln);
      chki("vec_len", dc - 1, vecs[i].exp_len);
      chki("vec_byte", int'(ln[8:1]), int'(vecs[i].byte_v));
      if (vecs[i].mode != 0) chk1("vec_parity", ln[9], vecs[i].exp_par);
      else chk1("vec_stop", ln[9], 1'b1);
    end

    // Single byte 0xA5, no parity: fixed line pattern, done on cycle 81
    send(0, 8'hA5, 0, 8'h00, dc, ln);
    chki("a5_line", int'(ln[9:0]), int'(10'b1101001010));
    chki("a5_done_cycle", dc, 81);

    // Busy ignore: 0x3C offered on cycle 20 of a 0x5A frame
    send(0, 8'h5A, 20, 8'h3C, dc, ln);
    chki("busy_byte", int'(ln[8:1]), 32'h5A);
    chki("busy_done_cycle", dc, 81);

    // Randomized loopback through the bench receiver
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom);
      md = int'($urandom_range(0, 2));
      send(md, rb, 0, 8'h00, dc, ln);
      chki("loop_byte", int'(ln[8:1]), int'(rb));
      chki("loop_len", dc - 1, frame_bits(md) * CPB);
    end

    // Back-to-back: tx_dv held high, 0x00 then 0xFF taken on the tx_done cycle
    d1 = -1;
    d2 = -1;
    pulses = 0;
    data = 8'h00;
    dv[0] = 1'b1;
    tick();
    data = 8'hFF;
    for (int k = 1; k <= 175; k++) begin
      if (dn[0]) begin
        pulses++;
        if (d1 < 0) d1 = k;
        else d2 = k;
      end
      if (k <= 80) chk1("b2b_first", ser[0], model_bit(8'h00, 0, (k - 1) / CPB));
      if (k >= 82 && k <= 161) chk1("b2b_second", ser[0], model_bit(8'hFF, 0, (k - 82) / CPB));
      if (k == 82) dv[0] = 1'b0;
      tick();
    end
    chki("b2b_pulses", pulses, 2);
    chki("b2b_first_done", d1, 81);
    // 80 cycles lie strictly between the two pulses
    chki("b2b_gap", d2 - d1 - 1, 80);

    // Mid-frame reset during data bit 3
    data = 8'hC3;
    dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    repeat (35) tick();
    chk1("mid_active_before", act[0], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("mid_serial", ser[0], 1'b1);
    chk1("mid_active", act[0], 1'b0);
    chk1("mid_ready", rdy[0], 1'b1);
    chk1("mid_done", dn[0], 1'b0);
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      if (dn[0] || !ser[0]) pulses++;
      tick();
    end
    chki("mid_quiet", pulses, 0);
    send(0, 8'h96, 0, 8'h00, dc, ln);
    chki("mid_after_byte", int'(ln[8:1]), 32'h96);
    chki("mid_after_done", dc, 81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
